// File: rtl/pic10_pkg.sv
// Shared types and encodings for the PIC10 instruction sequencer and decoder.
package pic10_pkg;

   localparam int unsigned IR_W     = 12;
   localparam int unsigned ALU_W    = 5;
   localparam int unsigned PC_SRC_W = 2;
   localparam int unsigned TRIS_W   = 3;

   typedef enum logic [2:0] {
      S_RST,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_SLEEP
   } state_t;

   localparam logic [ALU_W-1:0] ALU_ADD    = 5'd0;
   localparam logic [ALU_W-1:0] ALU_SUB    = 5'd1;
   localparam logic [ALU_W-1:0] ALU_AND    = 5'd2;
   localparam logic [ALU_W-1:0] ALU_IOR    = 5'd3;
   localparam logic [ALU_W-1:0] ALU_XOR    = 5'd4;
   localparam logic [ALU_W-1:0] ALU_COM    = 5'd5;
   localparam logic [ALU_W-1:0] ALU_INC    = 5'd6;
   localparam logic [ALU_W-1:0] ALU_DEC    = 5'd7;
   localparam logic [ALU_W-1:0] ALU_RR     = 5'd8;
   localparam logic [ALU_W-1:0] ALU_RL     = 5'd9;
   localparam logic [ALU_W-1:0] ALU_SWAP   = 5'd10;
   localparam logic [ALU_W-1:0] ALU_PASS_W = 5'd11;
   localparam logic [ALU_W-1:0] ALU_PASS_B = 5'd12;
   localparam logic [ALU_W-1:0] ALU_CLR    = 5'd13;
   localparam logic [ALU_W-1:0] ALU_BCLR   = 5'd14;
   localparam logic [ALU_W-1:0] ALU_BSET   = 5'd15;
   localparam logic [ALU_W-1:0] ALU_BTEST  = 5'd16;

   localparam logic [PC_SRC_W-1:0] PC_SRC_NONE  = 2'b00;
   localparam logic [PC_SRC_W-1:0] PC_SRC_GOTO  = 2'b01;
   localparam logic [PC_SRC_W-1:0] PC_SRC_CALL  = 2'b10;
   localparam logic [PC_SRC_W-1:0] PC_SRC_STACK = 2'b11;

   // Opcode groups: rows of ir[11:5], top-level quadrants of ir[11:10], branch rows.
   localparam logic [IR_W-1:0] OP_ROW_MASK   = 12'hFE0;
   localparam logic [IR_W-1:0] OP_MISC_MATCH = 12'h000;
   localparam logic [IR_W-1:0] OP_MOVWF_MATCH = 12'h020;
   localparam logic [IR_W-1:0] OP_CLRW_MATCH = 12'h040;
   localparam logic [IR_W-1:0] OP_CLRF_MATCH = 12'h060;
   localparam logic [IR_W-1:0] OP_GRP_MASK   = 12'hC00;
   localparam logic [IR_W-1:0] OP_BYTE_MATCH = 12'h000;
   localparam logic [IR_W-1:0] OP_BIT_MATCH  = 12'h400;
   localparam logic [IR_W-1:0] OP_GOTO_MASK  = 12'hE00;
   localparam logic [IR_W-1:0] OP_GOTO_MATCH = 12'hA00;
   localparam logic [IR_W-1:0] OP_BR_MASK    = 12'hF00;
   localparam logic [IR_W-1:0] OP_CALL_MATCH = 12'h900;
   localparam logic [IR_W-1:0] OP_RETLW_MATCH = 12'h800;

   typedef struct packed {
      logic [ALU_W-1:0]    alu_op;
      logic                alu_b_sel;
      logic [PC_SRC_W-1:0] pc_src;
      logic                load_pc;
      logic                push_stack;
      logic                pop_stack;
      logic                load_w;
      logic                load_file;
      logic                update_z;
      logic                update_c;
      logic [TRIS_W-1:0]   load_tris;
      logic                load_option;
      logic                skip_z;
      logic                skip_nz;
      logic                sleep;
   } ctrl_t;

   function automatic logic op_match(input logic [IR_W-1:0] ir,
                                     input logic [IR_W-1:0] mask,
                                     input logic [IR_W-1:0] match);
      return (ir & mask) == match;
   endfunction

endpackage

// File: rtl/pic10_decoder.sv
// Combinational decode of the 12-bit baseline instruction into a control bundle.
module pic10_decoder
   import pic10_pkg::*;
(
   input  logic [IR_W-1:0] ir,
   output ctrl_t           ctrl,
   output logic            illegal
);

   always_comb begin
      ctrl        = '0;
      ctrl.alu_op = ALU_PASS_W;
      ctrl.pc_src = PC_SRC_NONE;
      illegal     = 1'b0;

      if (op_match(ir, OP_ROW_MASK, OP_MISC_MATCH)) begin
         case (ir[4:0])
            5'd0, 5'd4: ;
            5'd2:    ctrl.load_option = 1'b1;
            5'd3:    ctrl.sleep       = 1'b1;
            5'd5:    ctrl.load_tris   = 3'b001;
            5'd6:    ctrl.load_tris   = 3'b010;
            5'd7:    ctrl.load_tris   = 3'b100;
            default: illegal          = 1'b1;
         endcase
      end else if (op_match(ir, OP_ROW_MASK, OP_MOVWF_MATCH)) begin
         ctrl.alu_op    = ALU_PASS_W;
         ctrl.load_file = 1'b1;
      end else if (op_match(ir, OP_ROW_MASK, OP_CLRW_MATCH)) begin
         if (ir[4:0] == 5'd0) begin
            ctrl.alu_op   = ALU_CLR;
            ctrl.load_w   = 1'b1;
            ctrl.update_z = 1'b1;
         end else begin
            illegal = 1'b1;
         end
      end else if (op_match(ir, OP_ROW_MASK, OP_CLRF_MATCH)) begin
         ctrl.alu_op    = ALU_CLR;
         ctrl.load_file = 1'b1;
         ctrl.update_z  = 1'b1;
      end else if (op_match(ir, OP_GRP_MASK, OP_BYTE_MATCH)) begin
         // Byte-oriented ops: d = ir[5] picks W or the file register as destination.
         ctrl.load_w    = ~ir[5];
         ctrl.load_file = ir[5];
         case (ir[9:6])
            4'h2: begin ctrl.alu_op = ALU_SUB; ctrl.update_z = 1'b1; ctrl.update_c = 1'b1; end
            4'h3: begin ctrl.alu_op = ALU_DEC; ctrl.update_z = 1'b1; end
            4'h4: begin ctrl.alu_op = ALU_IOR; ctrl.update_z = 1'b1; end
            4'h5: begin ctrl.alu_op = ALU_AND; ctrl.update_z = 1'b1; end
            4'h6: begin ctrl.alu_op = ALU_XOR; ctrl.update_z = 1'b1; end
            4'h7: begin ctrl.alu_op = ALU_ADD; ctrl.update_z = 1'b1; ctrl.update_c = 1'b1; end
            4'h8: begin ctrl.alu_op = ALU_PASS_B; ctrl.update_z = 1'b1; end
            4'h9: begin ctrl.alu_op = ALU_COM; ctrl.update_z = 1'b1; end
            4'hA: begin ctrl.alu_op = ALU_INC; ctrl.update_z = 1'b1; end
            4'hB: begin ctrl.alu_op = ALU_DEC; ctrl.skip_z = 1'b1; end
            4'hC: begin ctrl.alu_op = ALU_RR; ctrl.update_c = 1'b1; end
            4'hD: begin ctrl.alu_op = ALU_RL; ctrl.update_c = 1'b1; end
            4'hE: ctrl.alu_op = ALU_SWAP;
            4'hF: begin ctrl.alu_op = ALU_INC; ctrl.skip_z = 1'b1; end
            default: begin ctrl.load_w = 1'b0; ctrl.load_file = 1'b0; end
         endcase
      end else if (op_match(ir, OP_GRP_MASK, OP_BIT_MATCH)) begin
         case (ir[9:8])
            2'b00:   begin ctrl.alu_op = ALU_BCLR; ctrl.load_file = 1'b1; end
            2'b01:   begin ctrl.alu_op = ALU_BSET; ctrl.load_file = 1'b1; end
            2'b10:   begin ctrl.alu_op = ALU_BTEST; ctrl.skip_z = 1'b1; end
            default: begin ctrl.alu_op = ALU_BTEST; ctrl.skip_nz = 1'b1; end
         endcase
      end else if (op_match(ir, OP_GOTO_MASK, OP_GOTO_MATCH)) begin
         ctrl.load_pc = 1'b1;
         ctrl.pc_src  = PC_SRC_GOTO;
      end else if (op_match(ir, OP_BR_MASK, OP_CALL_MATCH)) begin
         ctrl.load_pc    = 1'b1;
         ctrl.push_stack = 1'b1;
         ctrl.pc_src     = PC_SRC_CALL;
      end else if (op_match(ir, OP_BR_MASK, OP_RETLW_MATCH)) begin
         ctrl.load_pc   = 1'b1;
         ctrl.pop_stack = 1'b1;
         ctrl.pc_src    = PC_SRC_STACK;
         ctrl.load_w    = 1'b1;
         ctrl.alu_b_sel = 1'b1;
         ctrl.alu_op    = ALU_PASS_B;
      end else begin
         // Literal ops into W.
         ctrl.alu_b_sel = 1'b1;
         ctrl.load_w    = 1'b1;
         case (ir[9:8])
            2'b00:   ctrl.alu_op = ALU_PASS_B;
            2'b01:   begin ctrl.alu_op = ALU_IOR; ctrl.update_z = 1'b1; end
            2'b10:   begin ctrl.alu_op = ALU_AND; ctrl.update_z = 1'b1; end
            default: begin ctrl.alu_op = ALU_XOR; ctrl.update_z = 1'b1; end
         endcase
      end
   end

endmodule

// File: rtl/pic10_control.sv
// PIC10 sequencer: FETCH/DECODE/EXEC state machine gating the decoded control bundle.
module pic10_control
   import pic10_pkg::*;
#(
   parameter bit SLEEP_EN = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IR_W-1:0]     ir_reg_bus,
   input  logic                alu_zero,
   output logic                load_ir_reg,
   output logic                inc_pc,
   output logic                load_pc,
   output logic [PC_SRC_W-1:0] pc_src,
   output logic                push_stack,
   output logic                pop_stack,
   output logic                load_w_reg,
   output logic                load_file_reg,
   output logic [ALU_W-1:0]    alu_op,
   output logic                alu_b_sel,
   output logic [2:0]          bit_sel,
   output logic [4:0]          file_addr,
   output logic                update_z,
   output logic                update_c,
   output logic [TRIS_W-1:0]   load_tris,
   output logic                load_option,
   output logic                sleeping,
   output logic                illegal_op
);

   state_t state;
   ctrl_t  dec;
   logic   dec_illegal;
   logic   in_fetch;
   logic   in_exec;
   logic   dec_valid;
   logic   skip_take;

   pic10_decoder u_decoder (
      .ir      (ir_reg_bus),
      .ctrl    (dec),
      .illegal (dec_illegal)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_RST;
         sleeping <= 1'b0;
      end else begin
         case (state)
            S_RST:    state <= S_FETCH;
            S_FETCH:  state <= S_DECODE;
            S_DECODE: state <= S_EXEC;
            S_EXEC: begin
               if (dec.sleep && SLEEP_EN) begin
                  state    <= S_SLEEP;
                  sleeping <= 1'b1;
               end else begin
                  state <= S_FETCH;
               end
            end
            S_SLEEP:  state <= S_SLEEP;
            default:  state <= S_RST;
         endcase
      end
   end

   // Decode fields come straight from the IR and alu_zero, so strobes follow state within the cycle.
   always_comb begin
      in_fetch  = (state == S_FETCH);
      in_exec   = (state == S_EXEC);
      dec_valid = (state == S_DECODE) || in_exec;
      skip_take = in_exec && ((dec.skip_z && alu_zero) || (dec.skip_nz && !alu_zero));

      load_ir_reg   = in_fetch;
      inc_pc        = in_fetch || skip_take;
      load_pc       = in_exec && dec.load_pc;
      push_stack    = in_exec && dec.push_stack;
      pop_stack     = in_exec && dec.pop_stack;
      load_w_reg    = in_exec && dec.load_w;
      load_file_reg = in_exec && dec.load_file;
      update_z      = in_exec && dec.update_z;
      update_c      = in_exec && dec.update_c;
      load_tris     = in_exec ? dec.load_tris : '0;
      load_option   = in_exec && dec.load_option;
      illegal_op    = in_exec && dec_illegal;

      alu_op        = dec_valid ? dec.alu_op : '0;
      alu_b_sel     = dec_valid && dec.alu_b_sel;
      pc_src        = dec_valid ? dec.pc_src : '0;
      bit_sel       = dec_valid ? ir_reg_bus[7:5] : '0;
      file_addr     = dec_valid ? ir_reg_bus[4:0] : '0;
   end

endmodule

// File: tb/tb_pic10_control.sv
// Randomized bench for pic10_control against a mnemonic-level reference model.
module tb_pic10_control;
   import pic10_pkg::*;

   localparam bit SLEEP_EN = 1'b1;
   localparam int PH_FETCH = 0;
   localparam int PH_DEC   = 1;
   localparam int PH_EXEC  = 2;
   localparam int PH_SLEEP = 3;
   localparam int PH_IDLE  = 4;

   typedef struct packed {
      logic       load_ir_reg;
      logic       inc_pc;
      logic       load_pc;
      logic [1:0] pc_src;
      logic       push_stack;
      logic       pop_stack;
      logic       load_w_reg;
      logic       load_file_reg;
      logic [4:0] alu_op;
      logic       alu_b_sel;
      logic [2:0] bit_sel;
      logic [4:0] file_addr;
      logic       update_z;
      logic       update_c;
      logic [2:0] load_tris;
      logic       load_option;
      logic       sleeping;
      logic       illegal_op;
   } bundle_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] ir_reg_bus;
   logic        alu_zero;
   logic        load_ir_reg, inc_pc, load_pc, push_stack, pop_stack;
   logic        load_w_reg, load_file_reg, alu_b_sel, update_z, update_c;
   logic        load_option, sleeping, illegal_op;
   logic [1:0]  pc_src;
   logic [4:0]  alu_op;
   logic [2:0]  bit_sel;
   logic [4:0]  file_addr;
   logic [2:0]  load_tris;

   int total = 0;
   int bad   = 0;
   bit asleep = 1'b0;

   pic10_control #(.SLEEP_EN(SLEEP_EN)) dut (
      .clk(clk), .reset(reset), .ir_reg_bus(ir_reg_bus), .alu_zero(alu_zero),
      .load_ir_reg(load_ir_reg), .inc_pc(inc_pc), .load_pc(load_pc), .pc_src(pc_src),
      .push_stack(push_stack), .pop_stack(pop_stack), .load_w_reg(load_w_reg),
      .load_file_reg(load_file_reg), .alu_op(alu_op), .alu_b_sel(alu_b_sel),
      .bit_sel(bit_sel), .file_addr(file_addr), .update_z(update_z), .update_c(update_c),
      .load_tris(load_tris), .load_option(load_option), .sleeping(sleeping),
      .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   function automatic bundle_t observe();
      bundle_t o;
      o.load_ir_reg = load_ir_reg;   o.inc_pc = inc_pc;         o.load_pc = load_pc;
      o.pc_src = pc_src;             o.push_stack = push_stack; o.pop_stack = pop_stack;
      o.load_w_reg = load_w_reg;     o.load_file_reg = load_file_reg;
      o.alu_op = alu_op;             o.alu_b_sel = alu_b_sel;   o.bit_sel = bit_sel;
      o.file_addr = file_addr;       o.update_z = update_z;     o.update_c = update_c;
      o.load_tris = load_tris;       o.load_option = load_option;
      o.sleeping = sleeping;         o.illegal_op = illegal_op;
      return o;
   endfunction

   function automatic string mnem(input logic [11:0] ir);
      int unsigned v = 32'(ir);
      if (v < 32'h020) begin
         case (v)
            0: return "NOP";
            2: return "OPTION";
            3: return "SLEEP";
            4: return "CLRWDT";
            5, 6, 7: return "TRIS";
            default: return "ILLEGAL";
         endcase
      end
      if (v < 32'h040) return "MOVWF";
      if (v < 32'h060) return (v == 32'h040) ? "CLRW" : "ILLEGAL";
      if (v < 32'h080) return "CLRF";
      if (v < 32'h400) begin
         case (v >> 6)
            2: return "SUBWF";   3: return "DECF";    4: return "IORWF";  5: return "ANDWF";
            6: return "XORWF";   7: return "ADDWF";   8: return "MOVF";   9: return "COMF";
            10: return "INCF";   11: return "DECFSZ"; 12: return "RRF";   13: return "RLF";
            14: return "SWAPF";  default: return "INCFSZ";
         endcase
      end
      if (v < 32'h800) begin
         case (v >> 8)
            4: return "BCF";  5: return "BSF";  6: return "BTFSC";  default: return "BTFSS";
         endcase
      end
      if (v < 32'h900) return "RETLW";
      if (v < 32'hA00) return "CALL";
      if (v < 32'hC00) return "GOTO";
      case (v >> 8)
         12: return "MOVLW";  13: return "IORLW";  14: return "ANDLW";  default: return "XORLW";
      endcase
   endfunction

   // Expected outputs and care-mask for one phase of one instruction.
   function automatic void model(input int ph, input logic [11:0] ir, input bit az,
                                 output bundle_t e, output bundle_t m);
      string nm = mnem(ir);
      bit byte_op, d;
      e = '0;
      m = '1;
      d = ir[5];
      byte_op = 1'b0;
      case (nm)
         "SUBWF", "DECF", "IORWF", "ANDWF", "XORWF", "ADDWF", "MOVF", "COMF",
         "INCF", "DECFSZ", "RRF", "RLF", "SWAPF", "INCFSZ": byte_op = 1'b1;
         default: ;
      endcase
      if (ph == PH_FETCH) begin
         e.load_ir_reg = 1'b1;
         e.inc_pc      = 1'b1;
      end else if (ph == PH_SLEEP) begin
         e.sleeping = 1'b1;
         m.alu_op = '0; m.alu_b_sel = 1'b0; m.bit_sel = '0; m.file_addr = '0; m.pc_src = '0;
      end else if (ph == PH_DEC || ph == PH_EXEC) begin
         e.bit_sel   = ir[7:5];
         e.file_addr = ir[4:0];
         case (nm)
            "GOTO":  e.pc_src = 2'b01;
            "CALL":  e.pc_src = 2'b10;
            "RETLW": e.pc_src = 2'b11;
            default: ;
         endcase
         case (nm)
            "ADDWF": e.alu_op = ALU_ADD;
            "SUBWF": e.alu_op = ALU_SUB;
            "ANDWF", "ANDLW": e.alu_op = ALU_AND;
            "IORWF", "IORLW": e.alu_op = ALU_IOR;
            "XORWF", "XORLW": e.alu_op = ALU_XOR;
            "COMF": e.alu_op = ALU_COM;
            "INCF", "INCFSZ": e.alu_op = ALU_INC;
            "DECF", "DECFSZ": e.alu_op = ALU_DEC;
            "RRF": e.alu_op = ALU_RR;
            "RLF": e.alu_op = ALU_RL;
            "SWAPF": e.alu_op = ALU_SWAP;
            "MOVWF": e.alu_op = ALU_PASS_W;
            "MOVF", "MOVLW", "RETLW": e.alu_op = ALU_PASS_B;
            "CLRW", "CLRF": e.alu_op = ALU_CLR;
            "BCF": e.alu_op = ALU_BCLR;
            "BSF": e.alu_op = ALU_BSET;
            "BTFSC", "BTFSS": e.alu_op = ALU_BTEST;
            default: begin m.alu_op = '0; m.alu_b_sel = 1'b0; end
         endcase
         case (nm)
            "MOVLW", "IORLW", "ANDLW", "XORLW", "RETLW": e.alu_b_sel = 1'b1;
            default: ;
         endcase
         if (ph == PH_EXEC) begin
            case (nm)
               "CLRW", "MOVLW", "IORLW", "ANDLW", "XORLW", "RETLW": e.load_w_reg = 1'b1;
               default: e.load_w_reg = byte_op && !d;
            endcase
            case (nm)
               "MOVWF", "CLRF", "BCF", "BSF": e.load_file_reg = 1'b1;
               default: e.load_file_reg = byte_op && d;
            endcase
            case (nm)
               "CLRW", "CLRF", "SUBWF", "DECF", "IORWF", "ANDWF", "XORWF", "ADDWF",
               "MOVF", "COMF", "INCF", "IORLW", "ANDLW", "XORLW": e.update_z = 1'b1;
               default: ;
            endcase
            case (nm)
               "ADDWF", "SUBWF", "RRF", "RLF": e.update_c = 1'b1;
               default: ;
            endcase
            case (nm)
               "DECFSZ", "INCFSZ", "BTFSC": e.inc_pc = az;
               "BTFSS": e.inc_pc = !az;
               "GOTO": e.load_pc = 1'b1;
               "CALL": begin e.load_pc = 1'b1; e.push_stack = 1'b1; end
               "RETLW": begin e.load_pc = 1'b1; e.pop_stack = 1'b1; end
               "TRIS": e.load_tris = 3'(1 << (32'(ir[4:0]) - 5));
               "OPTION": e.load_option = 1'b1;
               "ILLEGAL": e.illegal_op = 1'b1;
               default: ;
            endcase
         end
      end
   endfunction

   function automatic string ph_name(input int ph);
      case (ph)
         PH_FETCH: return "fetch";
         PH_DEC:   return "decode";
         PH_EXEC:  return "exec";
         PH_SLEEP: return "sleep";
         default:  return "reset";
      endcase
   endfunction

   task automatic check_phase(input int ph, input logic [11:0] ir, input bit az, input string tag);
      bundle_t e, m;
      model(ph, ir, az, e, m);
      chk($sformatf("%s %s ir=%03h az=%0d", tag, ph_name(ph), ir, az),
          32'(observe() & m), 32'(e & m));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      check_phase(PH_IDLE, ir_reg_bus, 1'b0, "rst_async");
      asleep = 1'b0;
      @(negedge clk);
      check_phase(PH_IDLE, ir_reg_bus, 1'b0, "rst_hold");
      reset = 1'b1;
   endtask

   // Called just before the edge that enters FETCH; returns after the EXEC sample.
   task automatic run_instr(input logic [11:0] ir, input bit az, input int abort_ph);
      for (int ph = PH_FETCH; ph <= PH_EXEC; ph++) begin
         @(posedge clk);
         #1;
         if (ph == PH_DEC) ir_reg_bus = ir;
         alu_zero = (ph == PH_EXEC) ? az : 1'($urandom);
         @(negedge clk);
         check_phase(ph, ir, az, "instr");
         if (ph == abort_ph) begin
            #2;
            do_reset();
            return;
         end
      end
      if (SLEEP_EN && mnem(ir) == "SLEEP") asleep = 1'b1;
   endtask

   task automatic sleep_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         ir_reg_bus = 12'($urandom);
         alu_zero   = 1'($urandom);
         @(negedge clk);
         check_phase(PH_SLEEP, ir_reg_bus, alu_zero, "asleep");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b0;
      ir_reg_bus = 12'h000;
      alu_zero   = 1'b0;
      @(negedge clk);
      check_phase(PH_IDLE, ir_reg_bus, 1'b0, "por");
      @(negedge clk);
      check_phase(PH_IDLE, ir_reg_bus, 1'b0, "por");
      reset = 1'b1;

      run_instr(12'h000, 1'b0, -1);
      run_instr(12'h1E5, 1'($urandom), -1);
      run_instr(12'h2EA, 1'b1, -1);
      run_instr(12'h2EA, 1'b0, -1);
      run_instr(12'hB23, 1'b0, -1);
      run_instr(12'h945, 1'b1, -1);
      run_instr(12'h87F, 1'b0, -1);
      run_instr(12'h006, 1'b0, -1);
      run_instr(12'h005, 1'b0, -1);
      run_instr(12'h007, 1'b1, -1);
      run_instr(12'h001, 1'b0, -1);
      run_instr(12'h008, 1'b0, -1);
      run_instr(12'h002, 1'b0, -1);
      run_instr(12'h004, 1'b0, -1);
      run_instr(12'h040, 1'b0, -1);
      run_instr(12'h041, 1'b0, -1);
      run_instr(12'h6A3, 1'b1, -1);
      run_instr(12'h6A3, 1'b0, -1);
      run_instr(12'h7A3, 1'b1, -1);
      run_instr(12'h7A3, 1'b0, -1);
      run_instr(12'h3F1, 1'b1, -1);

      run_instr(12'h003, 1'b0, -1);
      sleep_cycles(12);
      #2;
      do_reset();

      run_instr(12'h1E5, 1'b0, PH_DEC);
      run_instr(12'h945, 1'b0, PH_EXEC);
      run_instr(12'h000, 1'b0, -1);

      for (int n = 0; n < 400; n++) begin
         logic [11:0] r;
         int          ab;
         r  = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 127))
                                          : 12'($urandom_range(0, 4095));
         ab = ($urandom_range(0, 40) == 0) ? int'($urandom_range(1, 2)) : -1;
         run_instr(r, 1'($urandom), ab);
         if (asleep) begin
            sleep_cycles(3);
            #2;
            do_reset();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
